// File: rtl/pc_sequencer.sv
// pc_sequencer -- fetch-side next-PC controller for the pipelined MIPS core.
//
// This module owns the fetch PC and steps it through instruction memory with a
// req/ready handshake. Jump and branch redirects take effect after one delay
// slot. Exceptions and eret redirect the PC at once and flush the fetch stage.
//
// Ports:
//   clk, reset         rising-edge clock; asynchronous active-low reset
//   stall              hazard-unit stall; blocks fetch acceptance
//   imem_ready         instruction memory has data for pc_out this cycle
//   br_valid/br_taken  resolved branch and its outcome
//   br_pc/br_offset    branch PC and raw 16-bit immediate
//   j_valid/j_target   resolved jump/jr and its destination
//   exc_req, eret_req  take an exception / return from one (destination epc)
//   pc_out, pc_plus4   current fetch address (registered) and that address + 4
//   imem_req           fetch request to instruction memory
//   fetch_valid        instruction at pc_out accepted into IF/ID this cycle
//   redirect_pending   a delayed jump/branch target is latched
module pc_sequencer #(
    parameter logic [31:0] PC_RESET   = 32'h0000_3000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        imem_ready,
    input  logic        br_valid,
    input  logic        br_taken,
    input  logic [31:0] br_pc,
    input  logic [15:0] br_offset,
    input  logic        j_valid,
    input  logic [31:0] j_target,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic        imem_req,
    output logic        fetch_valid,
    output logic        redirect_pending
);

    typedef enum logic [1:0] {BOOT, FETCH, FLUSH} state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic        pending_reg, pending_next;
    logic [31:0] pend_target_reg, pend_target_next;

    logic [31:0] br_target;
    logic        new_redirect;
    logic [31:0] new_target;
    logic        trap;
    logic [31:0] trap_pc;
    logic        accept;

    assign br_target    = br_pc + 32'd4 + {{14{br_offset[15]}}, br_offset, 2'b00};
    // When a jump and a taken branch arrive together, the jump wins.
    assign new_redirect = j_valid | (br_valid & br_taken);
    assign new_target   = j_valid ? j_target : br_target;
    assign trap         = exc_req | eret_req;
    // An exception takes priority over a simultaneous eret.
    assign trap_pc      = exc_req ? EXC_VECTOR : epc;
    assign accept       = (state_reg == FETCH) & imem_ready & ~stall & ~trap;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= BOOT;
            pc_reg          <= PC_RESET;
            pending_reg     <= 1'b0;
            pend_target_reg <= 32'd0;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            pending_reg     <= pending_next;
            pend_target_reg <= pend_target_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        pc_next          = pc_reg;
        pending_next     = pending_reg;
        pend_target_next = pend_target_reg;
        imem_req         = 1'b0;
        fetch_valid      = 1'b0;

        // A redirect with no accept in its cycle waits for the next accept.
        // If a target is already latched, the new redirect is dropped.
        if (new_redirect && !pending_reg && !accept) begin
            pending_next     = 1'b1;
            pend_target_next = new_target;
        end

        case (state_reg)
            BOOT: begin
                state_next = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (trap) begin
                    pc_next      = trap_pc;
                    pending_next = 1'b0;
                    state_next   = FLUSH;
                end else if (accept) begin
                    fetch_valid = 1'b1;
                    // The accepted fetch is the delay slot; the target follows.
                    // A latched target is older than any redirect arriving now,
                    // so it is consumed first and the newcomer is dropped.
                    if (pending_reg) begin
                        pc_next      = pend_target_reg;
                        pending_next = 1'b0;
                    end else if (new_redirect) begin
                        pc_next = new_target;
                    end else begin
                        pc_next = pc_reg + 32'd4;
                    end
                end
            end
            FLUSH: begin
                state_next = FETCH;
                if (trap) begin
                    pc_next      = trap_pc;
                    pending_next = 1'b0;
                    state_next   = FLUSH;
                end
            end
            default: begin
                state_next = BOOT;
            end
        endcase
    end

    assign pc_out           = pc_reg;
    assign pc_plus4         = pc_reg + 32'd4;
    assign redirect_pending = pending_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer: each task drives one scenario and
// compares outputs against hand-computed values.
module tb_pc_sequencer;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        imem_ready;
    logic        br_valid;
    logic        br_taken;
    logic [31:0] br_pc;
    logic [15:0] br_offset;
    logic        j_valid;
    logic [31:0] j_target;
    logic        exc_req;
    logic        eret_req;
    logic [31:0] epc;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        imem_req;
    logic        fetch_valid;
    logic        redirect_pending;

    int errors = 0;
    int checks = 0;

    pc_sequencer dut (
        .clk(clk), .reset(reset), .stall(stall), .imem_ready(imem_ready),
        .br_valid(br_valid), .br_taken(br_taken), .br_pc(br_pc), .br_offset(br_offset),
        .j_valid(j_valid), .j_target(j_target), .exc_req(exc_req), .eret_req(eret_req),
        .epc(epc), .pc_out(pc_out), .pc_plus4(pc_plus4), .imem_req(imem_req),
        .fetch_valid(fetch_valid), .redirect_pending(redirect_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; stall = 1'b0; imem_ready = 1'b1;
        br_valid = 1'b0; br_taken = 1'b0; br_pc = 32'd0; br_offset = 16'd0;
        j_valid = 1'b0; j_target = 32'd0; exc_req = 1'b0; eret_req = 1'b0; epc = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (pc_out !== 32'h3000) begin errors++; $display("FAIL reset_pc: got %h expected %h", pc_out, 32'h3000); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", imem_req); end
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL reset_fv: got %b expected 0", fetch_valid); end
        checks++; if (redirect_pending !== 1'b0) begin errors++; $display("FAIL reset_pend: got %b expected 0", redirect_pending); end
        reset = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL boot_req: got %b expected 0", imem_req); end
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL boot_fv: got %b expected 0", fetch_valid); end
        $display("reset: released, BOOT pc=%h", pc_out);
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc;
        exp_pc = 32'h3000;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL seq_req[%0d]: got %b expected 1", i, imem_req); end
            checks++; if (fetch_valid !== 1'b1) begin errors++; $display("FAIL seq_fv[%0d]: got %b expected 1", i, fetch_valid); end
            checks++; if (pc_out !== exp_pc) begin errors++; $display("FAIL seq_pc[%0d]: got %h expected %h", i, pc_out, exp_pc); end
            checks++; if (pc_plus4 !== exp_pc + 32'd4) begin errors++; $display("FAIL seq_plus4[%0d]: got %h expected %h", i, pc_plus4, exp_pc + 32'd4); end
            $display("fetch: pc=%h", pc_out);
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    task automatic test_branch();
        // Taken branch at 0x3004, offset -2 words -> target 0x3000; 0x3008 is the delay slot.
        br_valid = 1'b1; br_taken = 1'b1; br_pc = 32'h3004; br_offset = 16'hFFFE;
        #1;
        checks++; if (fetch_valid !== 1'b1) begin errors++; $display("FAIL br_slot_fv: got %b expected 1", fetch_valid); end
        checks++; if (pc_out !== 32'h3008) begin errors++; $display("FAIL br_slot_pc: got %h expected %h", pc_out, 32'h3008); end
        tick();
        br_valid = 1'b0; br_taken = 1'b0;
        checks++; if (pc_out !== 32'h3000) begin errors++; $display("FAIL br_target: got %h expected %h", pc_out, 32'h3000); end
        checks++; if (redirect_pending !== 1'b0) begin errors++; $display("FAIL br_pend: got %b expected 0", redirect_pending); end
        $display("branch: taken -> pc=%h", pc_out);
        // Not-taken branch: sequential.
        br_valid = 1'b1; br_taken = 1'b0; br_pc = 32'h3004; br_offset = 16'h0010;
        tick();
        br_valid = 1'b0;
        checks++; if (pc_out !== 32'h3004) begin errors++; $display("FAIL br_nt: got %h expected %h", pc_out, 32'h3004); end
        $display("branch: not taken -> pc=%h", pc_out);
        // Wrap-around: 0xFFFFFFF8 + 4 + 4 = 0x00000000.
        br_valid = 1'b1; br_taken = 1'b1; br_pc = 32'hFFFF_FFF8; br_offset = 16'h0001;
        tick();
        br_valid = 1'b0; br_taken = 1'b0;
        checks++; if (pc_out !== 32'h0000_0000) begin errors++; $display("FAIL br_wrap: got %h expected %h", pc_out, 32'h0); end
        $display("branch: wrap -> pc=%h", pc_out);
        // Jump and taken branch together: the jump wins (branch would go to 0x3104).
        j_valid = 1'b1; j_target = 32'h3004;
        br_valid = 1'b1; br_taken = 1'b1; br_pc = 32'h3100; br_offset = 16'h0000;
        tick();
        j_valid = 1'b0; br_valid = 1'b0; br_taken = 1'b0;
        checks++; if (pc_out !== 32'h3004) begin errors++; $display("FAIL j_over_br: got %h expected %h", pc_out, 32'h3004); end
        $display("jump+branch: jump wins -> pc=%h", pc_out);
    endtask

    task automatic test_stalled_jump();
        stall = 1'b1; j_valid = 1'b1; j_target = 32'h3100;
        #1;
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL stall_fv: got %b expected 0", fetch_valid); end
        tick();
        j_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++; if (redirect_pending !== 1'b1) begin errors++; $display("FAIL stall_pend[%0d]: got %b expected 1", i, redirect_pending); end
            checks++; if (pc_out !== 32'h3004) begin errors++; $display("FAIL stall_hold[%0d]: got %h expected %h", i, pc_out, 32'h3004); end
            tick();
        end
        stall = 1'b0;
        #1;
        checks++; if (fetch_valid !== 1'b1) begin errors++; $display("FAIL slot_fv: got %b expected 1", fetch_valid); end
        checks++; if (pc_out !== 32'h3004) begin errors++; $display("FAIL slot_pc: got %h expected %h", pc_out, 32'h3004); end
        tick();
        checks++; if (pc_out !== 32'h3100) begin errors++; $display("FAIL pend_target: got %h expected %h", pc_out, 32'h3100); end
        checks++; if (redirect_pending !== 1'b0) begin errors++; $display("FAIL pend_clear: got %b expected 0", redirect_pending); end
        $display("stalled jump: applied -> pc=%h", pc_out);
        tick();
        checks++; if (pc_out !== 32'h3104) begin errors++; $display("FAIL post_jump: got %h expected %h", pc_out, 32'h3104); end
    endtask

    task automatic test_exception();
        j_valid = 1'b1; j_target = 32'h3020;
        tick();
        j_valid = 1'b0;
        checks++; if (pc_out !== 32'h3020) begin errors++; $display("FAIL exc_setup_pc: got %h expected %h", pc_out, 32'h3020); end
        imem_ready = 1'b0; j_valid = 1'b1; j_target = 32'h3200;
        tick();
        j_valid = 1'b0; imem_ready = 1'b1;
        checks++; if (redirect_pending !== 1'b1) begin errors++; $display("FAIL exc_setup_pend: got %b expected 1", redirect_pending); end
        exc_req = 1'b1;
        #1;
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL exc_fv: got %b expected 0", fetch_valid); end
        tick();
        exc_req = 1'b0;
        checks++; if (pc_out !== 32'h4180) begin errors++; $display("FAIL exc_pc: got %h expected %h", pc_out, 32'h4180); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL exc_flush_req: got %b expected 0", imem_req); end
        checks++; if (redirect_pending !== 1'b0) begin errors++; $display("FAIL exc_pend: got %b expected 0", redirect_pending); end
        tick();
        checks++; if (imem_req !== 1'b1 || fetch_valid !== 1'b1) begin errors++; $display("FAIL exc_resume: got req=%b fv=%b expected 1/1", imem_req, fetch_valid); end
        checks++; if (pc_out !== 32'h4180) begin errors++; $display("FAIL exc_resume_pc: got %h expected %h", pc_out, 32'h4180); end
        tick();
        checks++; if (pc_out !== 32'h4184) begin errors++; $display("FAIL exc_next: got %h expected %h", pc_out, 32'h4184); end
        $display("exception: vector taken, pc=%h", pc_out);
    endtask

    task automatic test_exc_eret();
        exc_req = 1'b1; eret_req = 1'b1; epc = 32'h3050;
        tick();
        exc_req = 1'b0; eret_req = 1'b0;
        checks++; if (pc_out !== 32'h4180) begin errors++; $display("FAIL exc_prio: got %h expected %h", pc_out, 32'h4180); end
        tick();
        eret_req = 1'b1;
        #1;
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL eret_fv: got %b expected 0", fetch_valid); end
        tick();
        eret_req = 1'b0;
        checks++; if (pc_out !== 32'h3050) begin errors++; $display("FAIL eret_pc: got %h expected %h", pc_out, 32'h3050); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL eret_flush: got %b expected 0", imem_req); end
        tick();
        checks++; if (fetch_valid !== 1'b1 || pc_out !== 32'h3050) begin errors++; $display("FAIL eret_resume: got fv=%b pc=%h expected 1/%h", fetch_valid, pc_out, 32'h3050); end
        $display("eret: returned to pc=%h", pc_out);
        // Exception arriving during FLUSH reloads the PC and stays in FLUSH.
        eret_req = 1'b1; epc = 32'h3060;
        tick();
        eret_req = 1'b0; exc_req = 1'b1;
        tick();
        exc_req = 1'b0;
        checks++; if (pc_out !== 32'h4180 || imem_req !== 1'b0) begin errors++; $display("FAIL flush_reload: got pc=%h req=%b expected %h/0", pc_out, imem_req, 32'h4180); end
        tick();
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL flush_exit: got %b expected 1", imem_req); end
        $display("flush reload: pc=%h", pc_out);
    endtask

    task automatic test_reset_mid();
        imem_ready = 1'b0; j_valid = 1'b1; j_target = 32'h3300;
        tick();
        j_valid = 1'b0;
        checks++; if (redirect_pending !== 1'b1) begin errors++; $display("FAIL rst_setup_pend: got %b expected 1", redirect_pending); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if (pc_out !== 32'h3000) begin errors++; $display("FAIL rst_async_pc: got %h expected %h", pc_out, 32'h3000); end
        checks++; if (imem_req !== 1'b0 || redirect_pending !== 1'b0) begin errors++; $display("FAIL rst_async_out: got req=%b pend=%b expected 0/0", imem_req, redirect_pending); end
        imem_ready = 1'b1;
        tick();
        reset = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_boot: got %b expected 0", imem_req); end
        tick();
        tick();
        checks++; if (pc_out !== 32'h3004) begin errors++; $display("FAIL rst_no_pend: got %h expected %h", pc_out, 32'h3004); end
        $display("mid reset: restarted, pc=%h", pc_out);
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_stalled_jump();
        test_exception();
        test_exc_eret();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
